// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM:SS timekeeper.
//   state_e      : controller state; its code doubles as the field_sel value
//   MAX_* / *_W  : field limits and register widths
//   field_right / field_left : cyclic field navigation in set mode
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_e;

  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;
  localparam int MAX_SEC  = 59;
  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;

  // HH -> MM -> SS -> HH
  function automatic state_e field_right(input state_e s);
    state_e r;
    case (s)
      SET_HH:  r = SET_MM;
      SET_MM:  r = SET_SS;
      default: r = SET_HH;
    endcase
    return r;
  endfunction

  // HH -> SS -> MM -> HH
  function automatic state_e field_left(input state_e s);
    state_e r;
    case (s)
      SET_HH:  r = SET_SS;
      SET_SS:  r = SET_MM;
      default: r = SET_HH;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clock_field_counter.sv
// Wrapping field register for one time field (hours, minutes or seconds).
//   clk, reset : clock, asynchronous active-high reset (value -> 0)
//   inc, dec   : step up / down with wrap; inc wins if both are set
//   value      : registered field value, always 0..MAX
//   carry_out  : combinational, high when inc is applied at MAX
module clock_field_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         carry_out
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] value_q, value_d;

  // Explicit compare-to-limit keeps the register in range without modulo.
  always_comb begin
    value_d = value_q;
    if (inc) begin
      value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
    end else if (dec) begin
      value_d = (value_q == '0) ? MAX_V : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value     = value_q;
  assign carry_out = inc && (value_q == MAX_V);

endmodule

// File: rtl/clock_time_setter.sv
// 24-hour HH:MM:SS timekeeper with run / set modes, driven by one-cycle
// button pulses.
//   clk, reset               : clock, asynchronous active-high reset
//   pulseU/D/L/R/C           : one-cycle up/down/left/right/mode requests
//   hours, minutes, seconds  : current time (binary)
//   set_mode                 : high in any SET state
//   field_sel                : 0=RUN, 1=HH, 2=MM, 3=SS
//   blink                    : blink phase for the selected field, 0 in RUN
//   sec_tick                 : one-cycle pulse when seconds advance in RUN
//
// state  | meaning
// RUN    | time advances once per TICK_DIV cycles, only C is honoured
// SET_HH | time frozen, U/D edit hours
// SET_MM | time frozen, U/D edit minutes
// SET_SS | time frozen, U/D edit seconds
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulseU,
  input  logic              pulseD,
  input  logic              pulseL,
  input  logic              pulseR,
  input  logic              pulseC,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic              set_mode,
  output logic [1:0]        field_sel,
  output logic              blink,
  output logic              sec_tick
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               sec_tick_q, sec_tick_d;
  logic               set_mode_q, set_mode_d;

  // One action per cycle, priority C > U > D > R > L.
  logic act_u, act_d, act_r, act_l;
  assign act_u = pulseU & ~pulseC;
  assign act_d = pulseD & ~pulseC & ~pulseU;
  assign act_r = pulseR & ~pulseC & ~pulseU & ~pulseD;
  assign act_l = pulseL & ~pulseC & ~pulseU & ~pulseD & ~pulseR;

  logic in_run, tick_wrap, run_adv;
  assign in_run    = (state_q == RUN);
  assign tick_wrap = in_run && (tick_cnt_q == TICK_LAST);
  // A mode change on the wrap cycle suppresses the second advance.
  assign run_adv   = tick_wrap & ~pulseC;

  logic sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;
  logic sec_carry, min_carry, hr_carry_unused;

  // Carries only ripple in RUN; set-mode edits stay inside their field.
  assign sec_inc = run_adv | ((state_q == SET_SS) & act_u);
  assign sec_dec = (state_q == SET_SS) & act_d;
  assign min_inc = (in_run & sec_carry) | ((state_q == SET_MM) & act_u);
  assign min_dec = (state_q == SET_MM) & act_d;
  assign hr_inc  = (in_run & min_carry) | ((state_q == SET_HH) & act_u);
  assign hr_dec  = (state_q == SET_HH) & act_d;

  clock_field_counter #(.MAX(MAX_SEC), .W(SEC_W)) u_sec (
    .clk       (clk),
    .reset     (reset),
    .inc       (sec_inc),
    .dec       (sec_dec),
    .value     (seconds),
    .carry_out (sec_carry)
  );

  clock_field_counter #(.MAX(MAX_MIN), .W(MIN_W)) u_min (
    .clk       (clk),
    .reset     (reset),
    .inc       (min_inc),
    .dec       (min_dec),
    .value     (minutes),
    .carry_out (min_carry)
  );

  clock_field_counter #(.MAX(MAX_HOUR), .W(HOUR_W)) u_hr (
    .clk       (clk),
    .reset     (reset),
    .inc       (hr_inc),
    .dec       (hr_dec),
    .value     (hours),
    .carry_out (hr_carry_unused)
  );

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    sec_tick_d  = 1'b0;

    case (state_q)
      RUN: begin
        blink_d     = 1'b0;
        blink_cnt_d = '0;
        if (pulseC) begin
          state_d    = SET_HH;
          tick_cnt_d = '0;
          blink_d    = 1'b1;
        end else if (tick_wrap) begin
          tick_cnt_d = '0;
          sec_tick_d = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      default: begin
        tick_cnt_d = '0;
        if (pulseC) begin
          // Counter restarts so the first tick lands TICK_DIV cycles later.
          state_d     = RUN;
          blink_d     = 1'b0;
          blink_cnt_d = '0;
        end else if (act_r | act_l) begin
          state_d     = act_r ? field_right(state_q) : field_left(state_q);
          blink_d     = 1'b1;
          blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_d     = ~blink_q;
          blink_cnt_d = '0;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    endcase

    set_mode_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      sec_tick_q  <= 1'b0;
      set_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      sec_tick_q  <= sec_tick_d;
      set_mode_q  <= set_mode_d;
    end
  end

  assign field_sel = state_q;
  assign set_mode  = set_mode_q;
  assign blink     = blink_q;
  assign sec_tick  = sec_tick_q;

endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- Sits directly downstream of the 5-button one-pulse stage.
- Consumes single-cycle pulses pulseU/D/L/R/C and maintains a 24-hour HH:MM:SS timekeeper.
- Provides a run mode (1 Hz advance) and a set mode (fields edited via buttons).
- Feeds the display driver with binary time, field selection and a blink flag.

Parameters:
TICK_DIV, 100_000_000, clk cycles per second tick (min 2)
BLINK_DIV, 25_000_000, clk cycles per blink phase toggle in set mode (min 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pulseU  input  1  one-cycle increment request
pulseD  input  1  one-cycle decrement request
pulseL  input  1  one-cycle move-field-left request
pulseR  input  1  one-cycle move-field-right request
pulseC  input  1  one-cycle mode toggle request
hours  output  5  current hours, 0..23
minutes  output  6  current minutes, 0..59
seconds  output  6  current seconds, 0..59
set_mode  output  1  1 while in any SET state
field_sel  output  2  0=none (RUN), 1=HH, 2=MM, 3=SS
blink  output  1  blink phase for selected field; 0 in RUN
sec_tick  output  1  one-cycle pulse when seconds advance in RUN

Behaviour:
- Reset is clock "clk", asynchronous, active-high "reset". During/after reset: state=RUN, hours=minutes=seconds=0, set_mode=0, field_sel=0, blink=0, sec_tick=0, tick and blink counters=0.
- All outputs are registered. The response to a pulse is visible on the clock edge after the pulse is sampled (1-cycle latency).
- States: RUN, SET_HH, SET_MM, SET_SS.
- RUN:
  - The tick counter counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1 it wraps to 0, sec_tick=1 on the next edge, and seconds increments.
  - Carry chain: seconds 59->0 carries minutes; minutes 59->0 carries hours; hours 23->0. 23:59:59 -> 00:00:00.
  - pulseU/D/L/R are ignored.
  - pulseC -> SET_HH, tick counter cleared, time held.
  - If pulseC coincides with the tick-wrap cycle, the mode change wins and seconds does not advance.
- SET_x:
  - Time is frozen, sec_tick=0, tick counter held at 0.
  - pulseU increments the selected field with wrap (HH 23->0, MM/SS 59->0). There is no carry into other fields.
  - pulseD decrements the selected field with wrap (HH 0->23, MM/SS 0->59). No borrow.
  - pulseR moves HH->MM->SS->HH; pulseL moves HH->SS->MM->HH.
  - pulseC -> RUN. The tick counter restarts at 0, so the first sec_tick occurs TICK_DIV cycles after exit.
- Simultaneous pulses: exactly one action per cycle, priority C > U > D > R > L. Lower-priority pulses that cycle are dropped, not queued.
- Blink:
  - On entry to any SET state, the blink counter is cleared and blink=1.
  - Blink toggles every BLINK_DIV cycles while in SET.
  - A field change (L/R) re-arms blink=1 and clears the counter.
  - U/D do not affect blink.
  - In RUN, blink=0 and the counter is held at 0.
- field_sel/set_mode track state on the same edge as the state register.
- Reset mid-operation (any state, any counter value) returns everything to reset values immediately (asynchronous).
- Field registers never hold out-of-range values. Increment/decrement arithmetic uses explicit compare-to-max, not modulo.

Decomposition:
- Shared package (clock_pkg):
  - State encoding: RUN=2'd0, SET_HH=2'd1, SET_MM=2'd2, SET_SS=2'd3. field_sel equals the state code.
  - Constants: MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59; widths HOUR_W=5, MIN_W=6.
- Sub-module clock_field_counter, instantiated for HH, MM and SS:
  - Parameters MAX and W.
  - Ports clk, reset, inc, dec, value, carry_out. carry_out is asserted when inc occurs at MAX.
  - Chaining: seconds inc is driven by the tick; minutes inc by seconds carry in RUN or pulseU in SET_MM.

Test Plan (TICK_DIV=4, BLINK_DIV=3):
- Release reset, run 4*60 cycles -> minutes=1, seconds=0, sec_tick pulsed 60 times, each 1 cycle wide, spaced 4 cycles.
- Set to 23:59:59 via SET mode, then pulseC back to RUN, wait 4 cycles -> 00:00:00, with sec_tick asserted once.
- RUN, pulseC -> set_mode=1, field_sel=1, blink=1. pulseD at hours=0 -> hours=23. pulseR twice -> field_sel=3. pulseU at seconds=59 -> seconds=0, minutes unchanged.
- In SET_MM, pulseU and pulseR in the same cycle -> minutes+1, field_sel stays 2. pulseC and pulseU together -> RUN, value unchanged.
- In SET_HH, hold 9 idle cycles -> blink sequence 1,1,1,0,0,0,1,1,1. A pulseR mid-phase -> blink=1 and the counter restarts.
- Assert reset asynchronously mid-cycle in SET_SS with time 12:34:56 -> all outputs 0 and state RUN immediately, before the next clk edge.
